// File: rtl/flag_stack_register.sv
// Masked status-flag register with a DEPTH-entry LIFO save stack and an optional sticky copy (FLAG_STICKY_EN).
// Latency: every output is registered, so an effect is visible one cycle after the sampling edge.
// Backpressure: none. A push when full or a pop when empty is dropped and reported by a one-cycle stack_err pulse.
module flag_stack_register #(
    parameter  int FLAG_W = 4,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              execute,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] wr_mask,
    input  logic              push,
    input  logic              pop,
    input  logic              sticky_clr,
    output logic [FLAG_W-1:0] out,
    output logic [FLAG_W-1:0] sticky,
    output logic [CNT_W-1:0]  depth_cnt,
    output logic              full,
    output logic              empty,
    output logic              stack_err
);

    logic [FLAG_W-1:0] stack_q [DEPTH];
    logic [FLAG_W-1:0] top;
    logic              do_push;
    logic              do_pop;
    logic              err_req;

    assign full  = (depth_cnt == CNT_W'(DEPTH));
    assign empty = (depth_cnt == '0);

    // A simultaneous push and pop cancel: the stack is left untouched and no error is raised.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign err_req = (push & ~pop & full) | (pop & ~push & empty);

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_cnt == CNT_W'(i + 1)) top = stack_q[i];
        end
    end

    // Stack contents need no reset; depth_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && depth_cnt == CNT_W'(i)) stack_q[i] <= out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            depth_cnt <= '0;
            stack_err <= 1'b0;
        end else begin
            stack_err <= err_req;
            if (do_pop)
                out <= top;
            else if (execute)
                out <= (out & ~wr_mask) | (flags_in & wr_mask);
            if (do_push)
                depth_cnt <= depth_cnt + CNT_W'(1);
            else if (do_pop)
                depth_cnt <= depth_cnt - CNT_W'(1);
        end
    end

`ifdef FLAG_STICKY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky <= '0;
        else if (execute)
            sticky <= (sticky_clr ? '0 : sticky) | (flags_in & wr_mask);
        else if (sticky_clr)
            sticky <= '0;
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky            = '0;
`endif

endmodule

// File: tb/tb_flag_stack_register.sv
// Scoreboard bench for flag_stack_register: expected results are queued per cycle and checked by a monitor.
module tb_flag_stack_register;

`ifdef FLAG_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       execute, push, pop, sticky_clr;
    logic [3:0] flags_in, wr_mask;
    logic [3:0] out, sticky;
    logic [2:0] depth_cnt;
    logic       full, empty, stack_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         id;
        logic [3:0] e_out;
        logic [3:0] e_stk;
        logic [2:0] e_cnt;
        logic       e_err;
    } exp_t;

    exp_t exp_q[$];

    flag_stack_register #(.FLAG_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .execute(execute), .flags_in(flags_in),
        .wr_mask(wr_mask), .push(push), .pop(pop), .sticky_clr(sticky_clr),
        .out(out), .sticky(sticky), .depth_cnt(depth_cnt), .full(full),
        .empty(empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s step %0d: got %b expected %b", name, id, act, req);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("out", e.id, out, e.e_out);
        chk("sticky", e.id, sticky, STICKY_ON ? e.e_stk : 4'b0000);
        chk("depth_cnt", e.id, {1'b0, depth_cnt}, {1'b0, e.e_cnt});
        chk("full", e.id, {3'b0, full}, {3'b0, (e.e_cnt == 3'd4)});
        chk("empty", e.id, {3'b0, empty}, {3'b0, (e.e_cnt == 3'd0)});
        chk("stack_err", e.id, {3'b0, stack_err}, {3'b0, e.e_err});
    endtask

    // Monitor: one result is due per clock after each issued vector.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) chk_all(exp_q.pop_front());
        end
    end

    int step_id = 0;

    task automatic cyc(input logic ex, input logic [3:0] fin, input logic [3:0] msk,
                       input logic psh, input logic pp, input logic clr,
                       input logic [3:0] e_out, input logic [3:0] e_stk,
                       input logic [2:0] e_cnt, input logic e_err);
        exp_t e;
        @(negedge clk);
        execute = ex; flags_in = fin; wr_mask = msk; push = psh; pop = pp; sticky_clr = clr;
        step_id++;
        e.id = step_id; e.e_out = e_out; e.e_stk = e_stk; e.e_cnt = e_cnt; e.e_err = e_err;
        exp_q.push_back(e);
    endtask

    task automatic reset_check(input int id);
        exp_t e;
        e.id = id; e.e_out = 4'b0; e.e_stk = 4'b0; e.e_cnt = 3'd0; e.e_err = 1'b0;
        chk_all(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        execute = 0; flags_in = 0; wr_mask = 0; push = 0; pop = 0; sticky_clr = 0;
        #12;
        reset_check(0);
        @(negedge clk);
        rst_n = 1'b1;

        //    ex fin      msk      psh pp clr  out      sticky   cnt err
        cyc(1, 4'b1011, 4'b1111, 0, 0, 0, 4'b1011, 4'b1011, 0, 0);
        cyc(1, 4'b0100, 4'b0100, 0, 0, 0, 4'b1111, 4'b1111, 0, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b1111, 4'b0000, 0, 0);
        cyc(1, 4'b0001, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 0, 0);
        cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0001, 4'b0001, 1, 0);
        cyc(1, 4'b1000, 4'b1111, 0, 0, 0, 4'b1000, 4'b1001, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0001, 4'b1001, 0, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0001, 4'b0000, 0, 0);
        cyc(1, 4'b0001, 4'b1111, 0, 0, 0, 4'b0001, 4'b0001, 0, 0);
        cyc(1, 4'b0100, 4'b1111, 0, 0, 0, 4'b0100, 4'b0101, 0, 0);
        cyc(1, 4'b0010, 4'b1111, 0, 0, 1, 4'b0010, 4'b0010, 0, 0);
        // fill the stack, each push saving the pre-execute value
        cyc(1, 4'b0011, 4'b1111, 1, 0, 0, 4'b0011, 4'b0011, 1, 0);
        cyc(1, 4'b0101, 4'b1111, 1, 0, 0, 4'b0101, 4'b0111, 2, 0);
        cyc(1, 4'b0110, 4'b1111, 1, 0, 0, 4'b0110, 4'b0111, 3, 0);
        cyc(1, 4'b1000, 4'b1111, 1, 0, 0, 4'b1000, 4'b1111, 4, 0);
        cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b1000, 4'b1111, 4, 1);
        cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1000, 4'b1111, 4, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0110, 4'b1111, 3, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0101, 4'b1111, 2, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0011, 4'b1111, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0010, 4'b1111, 0, 0);
        cyc(1, 4'b0110, 4'b1111, 0, 1, 0, 4'b0110, 4'b1111, 0, 1);
        cyc(1, 4'b1001, 4'b0011, 0, 0, 0, 4'b0101, 4'b1111, 0, 0);
        cyc(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0101, 4'b1111, 1, 0);
        cyc(1, 4'b1100, 4'b1111, 1, 0, 0, 4'b1100, 4'b1111, 2, 0);
        cyc(1, 4'b1010, 4'b1111, 1, 1, 0, 4'b1010, 4'b1111, 2, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0101, 4'b1111, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0101, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0101, 4'b0000, 1, 0);

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_check(100);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 4'b0000, 0, 1);
        cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
